// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle over XLEN cycles,
// with division-by-zero and signed-overflow cases resolved at issue.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_d;

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] hi, lo, opnd;
    logic [XLEN-1:0] hi_d, lo_d;
    logic [2:0]      op_q;
    logic            neg;

    logic            accept, last, special;
    logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs, special_res, final_res;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0] quo_s, rem_s;

    assign busy   = (state == CALC);
    assign valid  = (state == DONE);
    assign accept = start & ~flush & ((state == IDLE) | (state == DONE));
    assign last   = (cnt == CW'(XLEN - 1));

    // Operand decode on the live inputs; only consumed on the accepting edge.
    always_comb begin
        is_div = op[2];
        a_sgn  = is_div ? ~op[0] : (op[1:0] != 2'b11);
        b_sgn  = is_div ? ~op[0] : ~op[1];
        a_neg  = a_sgn & a[XLEN-1];
        b_neg  = b_sgn & b[XLEN-1];
        a_abs  = a_neg ? -a : a;
        b_abs  = b_neg ? -b : b;
        special = is_div & ((b == '0) | (~op[0] & (a == MOST_NEG) & (b == '1)));
        if (b == '0)
            special_res = op[1] ? a : '1;
        else
            special_res = op[1] ? '0 : a;
    end

    // Magnitude datapath: hi:lo is the product/partial product for multiplies,
    // remainder:quotient for divides; opnd holds multiplicand or divisor.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (op_q[2]) begin
            if (!div_diff[XLEN]) begin
                hi_d = div_diff[XLEN-1:0];
                lo_d = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_d = div_shift[XLEN-1:0];
                lo_d = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            {hi_d, lo_d} = {mul_sum, lo[XLEN-1:1]};
        end
    end

    always_comb begin
        prod   = {hi_d, lo_d};
        prod_s = neg ? -prod : prod;
        quo_s  = neg ? -lo_d : lo_d;
        rem_s  = neg ? -hi_d : hi_d;
        if (op_q[2])
            final_res = op_q[1] ? rem_s : quo_s;
        else if (op_q[1:0] == 2'b00)
            final_res = prod_s[XLEN-1:0];
        else
            final_res = prod_s[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = special ? DONE : CALC;
            CALC:    if (last) state_d = DONE;
            DONE:    state_d = accept ? (special ? DONE : CALC) : IDLE;
            default: state_d = IDLE;
        endcase
        if (flush)
            state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            op_q   <= '0;
            neg    <= 1'b0;
            result <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            op_q <= op;
            neg  <= (is_div & op[1]) ? a_neg : (a_neg ^ b_neg);
            cnt  <= '0;
            hi   <= '0;
            if (is_div) begin
                lo   <= a_abs;
                opnd <= b_abs;
            end else begin
                lo   <= b_abs;
                opnd <= a_abs;
            end
            if (special)
                result <= special_res;
        end else if (state == CALC) begin
            hi  <= hi_d;
            lo  <= lo_d;
            cnt <= cnt + 1'b1;
            if (last)
                result <= final_res;
        end
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN: default 32; operand and result width; even, >= 8.
REQ-002 SHALL have port clk: input, 1 bit; the single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst_n: input, 1 bit; synchronous, active-low reset.
REQ-004 SHALL have port start: input, 1 bit; request a new operation.
REQ-005 SHALL have port op: input, 3 bits; RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have ports a and b: inputs, XLEN bits each; rs1 and rs2 operands.
REQ-007 SHALL have port flush: input, 1 bit; abort any operation in progress.
REQ-008 SHALL have port busy: output, 1 bit; high only in state CALC.
REQ-009 SHALL have port valid: output, 1 bit; one-cycle completion pulse.
REQ-010 SHALL have port result: output, XLEN bits; registered result.

Function
REQ-011 SHALL implement an FSM with states IDLE, CALC and DONE; busy = (state==CALC); valid = (state==DONE).
REQ-012 SHALL accept start only when state is IDLE or DONE; op, a and b are captured on the accepting edge; start during CALC is ignored.
REQ-013 SHALL go from an accepted normal op to CALC for exactly XLEN cycles, then DONE; valid rises XLEN+1 cycles after the accept edge (33 for XLEN=32).
REQ-014 SHALL send these special cases straight to DONE (valid 1 cycle after accept) with:
  - DIV/DIVU with b==0: quotient all-ones.
  - REM/REMU with b==0: remainder = a.
  - DIV with a = most-negative and b = -1: quotient = a.
  - REM with a = most-negative and b = -1: remainder = 0.
REQ-015 SHALL treat operands as follows: MUL/MULH/DIV/REM signed x signed; MULHSU signed a x unsigned b; MULHU/DIVU/REMU unsigned.
REQ-016 SHALL compute the exact 2*XLEN product; MUL returns the low XLEN bits, MULH/MULHSU/MULHU return the high XLEN bits.
REQ-017 SHALL truncate division toward zero; the remainder takes the sign of the dividend.
REQ-018 SHALL use an iterative shift-add multiplier and a restoring/non-restoring divider, one bit per CALC cycle, with a $clog2(XLEN)-bit counter.
REQ-019 SHALL leave DONE after one cycle: to IDLE, or to CALC/DONE if start is accepted in DONE (back-to-back issue, no bubble).
REQ-020 SHALL update result only on entry to DONE and hold it stable until the next DONE entry.
REQ-021 SHALL, on flush, force IDLE on the next edge from any state, with no valid pulse and result unchanged.
REQ-022 SHALL give flush priority over start in the same cycle; that start is dropped.
REQ-023 SHALL NOT let operand inputs changing after the accept edge affect the operation in progress.

Reset
REQ-024 SHALL, with rst_n low at a clock edge, set state to IDLE, busy 0, valid 0, result 0 and counter 0, regardless of start or flush.
REQ-025 SHALL abort an in-flight operation on reset with no valid pulse; the unit accepts start on the first edge with rst_n high.

Verification
REQ-026 SHALL verify MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB with valid exactly 33 cycles after accept and busy high for 32 cycles.
REQ-027 SHALL verify the high-half multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-028 SHALL verify signed division: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU same operands -> 2.
REQ-029 SHALL verify the special cases, each with valid 1 cycle after accept:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
REQ-030 SHALL verify abort and ignore cases:
  - flush at accept+10 -> busy 0 next cycle, no valid, prior result retained, next start accepted.
  - start at accept+5 -> ignored.
  - simultaneous flush+start -> dropped.
REQ-031 SHALL verify that rst_n low at accept+20 gives all outputs 0 the next cycle with no valid, and that a back-to-back start issued in DONE produces two valid pulses 33 cycles apart.
